// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time reader and its BCD helpers.
package rtc_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitBusy,
      StWaitDone,
      StEvaluate
   } state_t;

   typedef struct packed {
      logic [4:0] hours;
      logic [5:0] minutes;
      logic [5:0] seconds;
   } rtc_time_t;

   localparam logic [7:0] RegPointer  = 8'h00;
   localparam logic [7:0] SecondsMask = 8'h7F;  // drops clock-halt bit
   localparam logic [7:0] HoursMask   = 8'h3F;  // drops 12/24 h mode bits

   // The master only moves on 1 ms ticks; allow two ticks plus margin.
   function automatic int waitBusyTimeout(input int clockFrequency);
      return 2 * (clockFrequency / 1000) + 4;
   endfunction

endpackage

// File: rtl/bcd_converter.sv
// Combinational two-digit BCD <-> binary converter, one instance per time field.
module bcd_converter
   import rtc_pkg::*;
(
   input  logic [6:0] binIn,
   output logic [7:0] bcdOut,
   input  logic [7:0] bcdIn,
   output logic [7:0] binOut,
   output logic       digitsValid
);

   always_comb begin
      bcdOut      = {4'(binIn / 7'd10), 4'(binIn % 7'd10)};
      binOut      = 8'(bcdIn[7:4]) * 8'd10 + 8'(bcdIn[3:0]);
      digitsValid = (bcdIn[7:4] <= 4'd9) && (bcdIn[3:0] <= 4'd9);
   end

endmodule

// File: rtl/rtc_time_reader.sv
// Polls a DS1307-class RTC through the I2C master, decodes BCD time, and
// writes a new time on request with retry and validation.
module rtc_time_reader
   import rtc_pkg::*;
#(
   parameter int         ClockFrequency = 1000000,
   parameter int         PollPeriodMs   = 1000,
   parameter logic [6:0] RtcAddress     = 7'h68,
   parameter int         MaxRetries     = 3,
   parameter int         MaxBytesToSend = 16,
   parameter int         MaxBytesToRead = 16
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                enable,
   input  logic                                setRequest,
   input  logic [4:0]                          setHours,
   input  logic [5:0]                          setMinutes,
   input  logic [5:0]                          setSeconds,
   output logic                                i2cStart,
   output logic [6:0]                          i2cAddress,
   output logic [$clog2(MaxBytesToSend):0]     i2cNrOfBytesToSend,
   output logic [MaxBytesToSend*8-1:0]         i2cBytesToSend,
   output logic [$clog2(MaxBytesToRead):0]     i2cNrOfBytesToRead,
   input  logic [MaxBytesToRead*8-1:0]         i2cBytesToRead,
   input  logic                                i2cReady,
   input  logic                                i2cClockStretchTimeoutReached,
   input  logic                                i2cNoAcknowledge,
   output logic [4:0]                          hours,
   output logic [5:0]                          minutes,
   output logic [5:0]                          seconds,
   output logic                                timeValid,
   output logic                                error,
   output logic                                setDone,
   output logic                                setRejected,
   output logic                                busy
);

   localparam int PollCycles    = PollPeriodMs * (ClockFrequency / 1000);
   localparam int PollWidth     = (PollCycles > 1) ? $clog2(PollCycles) : 1;
   localparam int TimeoutCycles = waitBusyTimeout(ClockFrequency);
   localparam int TimeoutWidth  = $clog2(TimeoutCycles + 1);
   localparam int RetryWidth    = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
   localparam int SendWidth     = $clog2(MaxBytesToSend) + 1;
   localparam int ReadWidth     = $clog2(MaxBytesToRead) + 1;

   localparam logic [PollWidth-1:0]    PollLast    = PollWidth'(PollCycles - 1);
   localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(TimeoutCycles - 1);
   localparam logic [RetryWidth-1:0]   RetryLimit  = RetryWidth'(MaxRetries);

   state_t                  state, nextState;
   logic [PollWidth-1:0]    pollCount;
   logic                    pollWrap, readRequest;
   rtc_time_t               setLatch;
   logic                    pendingSet, setInRange;
   logic                    launchRead, launchWrite, txnIsWrite;
   logic [TimeoutWidth-1:0] busyCount;
   logic                    timedOut;
   logic [RetryWidth-1:0]   retryCount;
   logic                    evalFail, readValid;
   logic [7:0]              secBcd, minBcd, hourBcd, secBin, minBin, hourBin;
   logic                    secOk, minOk, hourOk;
   logic                    unusedReadBytes;

   bcd_converter secConv (
      .binIn({1'b0, setLatch.seconds}), .bcdOut(secBcd),
      .bcdIn(i2cBytesToRead[7:0] & SecondsMask), .binOut(secBin), .digitsValid(secOk)
   );
   bcd_converter minConv (
      .binIn({1'b0, setLatch.minutes}), .bcdOut(minBcd),
      .bcdIn(i2cBytesToRead[15:8]), .binOut(minBin), .digitsValid(minOk)
   );
   bcd_converter hourConv (
      .binIn({2'b00, setLatch.hours}), .bcdOut(hourBcd),
      .bcdIn(i2cBytesToRead[23:16] & HoursMask), .binOut(hourBin), .digitsValid(hourOk)
   );

   assign unusedReadBytes = ^i2cBytesToRead[MaxBytesToRead*8-1:24];
   assign i2cAddress      = RtcAddress;
   assign i2cStart        = (state == StIssue);
   assign busy            = (state != StIdle);
   assign pollWrap        = (pollCount == PollLast);
   assign setInRange      = (setHours <= 5'd23) && (setMinutes <= 6'd59) && (setSeconds <= 6'd59);
   assign evalFail        = i2cNoAcknowledge | i2cClockStretchTimeoutReached | timedOut;
   assign readValid       = secOk && minOk && hourOk &&
                            (secBin <= 8'd59) && (minBin <= 8'd59) && (hourBin <= 8'd23);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= StIdle;
      else       state <= nextState;
   end

   always_comb begin
      nextState   = state;
      launchWrite = 1'b0;
      launchRead  = 1'b0;
      unique case (state)
         StIdle: begin
            if (pendingSet) begin
               launchWrite = 1'b1;
               nextState   = StIssue;
            end else if (readRequest) begin
               launchRead = 1'b1;
               nextState  = StIssue;
            end
         end
         StIssue:    nextState = StWaitBusy;
         StWaitBusy: begin
            if (!i2cReady)                  nextState = StWaitDone;
            else if (busyCount == TimeoutLast) nextState = StEvaluate;
         end
         StWaitDone: if (i2cReady) nextState = StEvaluate;
         StEvaluate: nextState = (evalFail && retryCount < RetryLimit) ? StIssue : StIdle;
         default:    nextState = StIdle;
      endcase
   end

   // The set latch is consumed at launch, so a set arriving mid-write queues a fresh write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pollCount   <= '0;
         readRequest <= 1'b0;
         setLatch    <= '0;
         pendingSet  <= 1'b0;
         setRejected <= 1'b0;
      end else begin
         pollCount   <= pollWrap ? '0 : pollCount + 1'b1;
         setRejected <= setRequest && !setInRange;
         if (pollWrap && enable) readRequest <= 1'b1;
         else if (launchRead)    readRequest <= 1'b0;
         if (setRequest && setInRange) begin
            setLatch   <= '{hours: setHours, minutes: setMinutes, seconds: setSeconds};
            pendingSet <= 1'b1;
         end else if (launchWrite) begin
            pendingSet <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         txnIsWrite         <= 1'b0;
         i2cNrOfBytesToSend <= '0;
         i2cBytesToSend     <= '0;
         i2cNrOfBytesToRead <= '0;
         busyCount          <= '0;
         timedOut           <= 1'b0;
         retryCount         <= '0;
      end else begin
         if (launchWrite) begin
            txnIsWrite         <= 1'b1;
            i2cNrOfBytesToSend <= SendWidth'(4);
            i2cNrOfBytesToRead <= '0;
            i2cBytesToSend     <= {{(MaxBytesToSend*8-32){1'b0}}, hourBcd & HoursMask,
                                   minBcd, secBcd & SecondsMask, RegPointer};
         end else if (launchRead) begin
            txnIsWrite         <= 1'b0;
            i2cNrOfBytesToSend <= SendWidth'(1);
            i2cNrOfBytesToRead <= ReadWidth'(3);
            i2cBytesToSend     <= {{(MaxBytesToSend*8-8){1'b0}}, RegPointer};
         end
         if (launchWrite || launchRead) retryCount <= '0;
         else if (state == StEvaluate)
            retryCount <= (evalFail && retryCount < RetryLimit) ? retryCount + 1'b1 : '0;
         if (state == StIssue) begin
            busyCount <= '0;
            timedOut  <= 1'b0;
         end else if (state == StWaitBusy && i2cReady) begin
            if (busyCount == TimeoutLast) timedOut  <= 1'b1;
            else                          busyCount <= busyCount + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hours     <= '0;
         minutes   <= '0;
         seconds   <= '0;
         timeValid <= 1'b0;
         error     <= 1'b0;
         setDone   <= 1'b0;
      end else begin
         setDone <= 1'b0;
         if (state == StEvaluate) begin
            if (evalFail) begin
               if (retryCount >= RetryLimit) error <= 1'b1;
            end else if (txnIsWrite) begin
               setDone <= 1'b1;
               error   <= 1'b0;
            end else if (readValid) begin
               hours     <= hourBin[4:0];
               minutes   <= minBin[5:0];
               seconds   <= secBin[5:0];
               timeValid <= 1'b1;
               error     <= 1'b0;
            end else begin
               error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rtc_time_reader.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor checks them.
module tb_rtc_time_reader;

   localparam int ClockFrequency = 10000;
   localparam int PollPeriodMs   = 20;
   localparam int PollCycles     = 200;

   logic         clock = 0, reset = 1, enable = 0, setRequest = 0;
   logic [4:0]   setHours = 0;
   logic [5:0]   setMinutes = 0, setSeconds = 0;
   logic         i2cStart;
   logic [6:0]   i2cAddress;
   logic [4:0]   i2cNrOfBytesToSend, i2cNrOfBytesToRead;
   logic [127:0] i2cBytesToSend;
   logic [127:0] i2cBytesToRead = '0;
   logic         i2cReady = 1, i2cClockStretchTimeoutReached = 0, i2cNoAcknowledge = 0;
   logic [4:0]   hours;
   logic [5:0]   minutes, seconds;
   logic         timeValid, error, setDone, setRejected, busy;

   rtc_time_reader #(.ClockFrequency(ClockFrequency), .PollPeriodMs(PollPeriodMs)) dut (
      .clock(clock), .reset(reset), .enable(enable), .setRequest(setRequest),
      .setHours(setHours), .setMinutes(setMinutes), .setSeconds(setSeconds),
      .i2cStart(i2cStart), .i2cAddress(i2cAddress),
      .i2cNrOfBytesToSend(i2cNrOfBytesToSend), .i2cBytesToSend(i2cBytesToSend),
      .i2cNrOfBytesToRead(i2cNrOfBytesToRead), .i2cBytesToRead(i2cBytesToRead),
      .i2cReady(i2cReady), .i2cClockStretchTimeoutReached(i2cClockStretchTimeoutReached),
      .i2cNoAcknowledge(i2cNoAcknowledge), .hours(hours), .minutes(minutes), .seconds(seconds),
      .timeValid(timeValid), .error(error), .setDone(setDone), .setRejected(setRejected),
      .busy(busy)
   );

   always #5 clock = ~clock;

   // kind: 0 start, 1 setRejected, 2 setDone, 3 end of transaction (busy falls)
   typedef struct {
      int          kind;
      int          sendCnt;
      logic [31:0] payload;
      int          readCnt;
      int          h, m, s;
      int          tv, err;
   } exp_t;

   exp_t        sb[$];
   int          startTimes[$];
   int          cyc = 0;
   int          checks = 0, errors = 0;
   logic [23:0] rdData = '0;
   bit          nackAll = 0;
   int          ignoreCnt = 0;
   logic        prevBusy = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input int kind, input int sc, input logic [31:0] pl, input int rc,
                       input int h, input int m, input int s, input int tv, input int err);
      exp_t e;
      e.kind = kind; e.sendCnt = sc; e.payload = pl; e.readCnt = rc;
      e.h = h; e.m = m; e.s = s; e.tv = tv; e.err = err;
      sb.push_back(e);
   endtask

   task automatic pop_check(input int kind);
      exp_t e;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_event: kind %0d seen at cycle %0d, none expected", kind, cyc);
         return;
      end
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      if (kind != e.kind) return;
      if (kind == 0) begin
         check("send_count", int'(i2cNrOfBytesToSend), e.sendCnt);
         check("payload", int'(i2cBytesToSend[31:0]), int'(e.payload));
         check("read_count", int'(i2cNrOfBytesToRead), e.readCnt);
         check("address", int'(i2cAddress), 'h68);
         startTimes.push_back(cyc);
      end else if (kind == 3) begin
         check("hours", int'(hours), e.h);
         check("minutes", int'(minutes), e.m);
         check("seconds", int'(seconds), e.s);
         check("time_valid", int'(timeValid), e.tv);
         check("error", int'(error), e.err);
      end
   endtask

   // Monitor
   initial forever begin
      @(negedge clock);
      if (i2cStart)          pop_check(0);
      if (setRejected)       pop_check(1);
      if (setDone)           pop_check(2);
      if (prevBusy && !busy) pop_check(3);
      prevBusy = busy;
   end

   // I2C master model: ready stays high a few cycles, then busy, then status and data.
   initial forever begin
      @(negedge clock);
      if (i2cStart === 1'b1) begin
         i2cNoAcknowledge = 0;
         if (ignoreCnt > 0) ignoreCnt--;
         else begin
            repeat (3) @(negedge clock);
            i2cReady = 0;
            repeat (5) @(negedge clock);
            i2cBytesToRead   = {104'h0, rdData};
            i2cNoAcknowledge = nackAll;
            i2cReady         = 1;
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL %s: %0d expected events outstanding after %0d cycles", name, sb.size(), budget);
         sb.delete();
      end
   endtask

   task automatic pulse_set(input int h, input int m, input int s);
      @(negedge clock);
      setHours = 5'(h); setMinutes = 6'(m); setSeconds = 6'(s);
      setRequest = 1;
      @(negedge clock);
      setRequest = 0;
   endtask

   logic [23:0] pollData [0:7];
   int          pollExp  [0:7][0:3];
   int          relCyc;
   int          n;

   initial begin
      pollData = '{24'h235945, 24'h000000, 24'h490587, 24'h01106A,
                   24'h102030, 24'h000060, 24'h240000, 24'h102030};
      pollExp  = '{'{23, 59, 45, 0}, '{0, 0, 0, 0}, '{9, 5, 7, 0}, '{9, 5, 7, 1},
                   '{10, 20, 30, 0}, '{10, 20, 30, 1}, '{10, 20, 30, 1}, '{10, 20, 30, 0}};

      repeat (3) @(negedge clock);
      check("reset_hours", int'(hours), 0);
      check("reset_time_valid", int'(timeValid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_start", int'(i2cStart), 0);
      check("reset_address", int'(i2cAddress), 'h68);
      reset = 0;

      // Out-of-range sets: rejected, no transaction
      push(1, 0, 0, 0, 0, 0, 0, 0, 0); pulse_set(24, 0, 0);
      push(1, 0, 0, 0, 0, 0, 0, 0, 0); pulse_set(0, 60, 0);
      push(1, 0, 0, 0, 0, 0, 0, 0, 0); pulse_set(0, 0, 60);
      wait_drain("set_reject", 10);
      repeat (20) @(negedge clock);

      // Writes, including the top legal value
      push(0, 4, 32'h12345600, 0, 0, 0, 0, 0, 0);
      push(2, 0, 0, 0, 0, 0, 0, 0, 0);
      push(3, 0, 0, 0, 0, 0, 0, 0, 0);
      pulse_set(12, 34, 56);
      wait_drain("write_123456", 100);
      push(0, 4, 32'h23595900, 0, 0, 0, 0, 0, 0);
      push(2, 0, 0, 0, 0, 0, 0, 0, 0);
      push(3, 0, 0, 0, 0, 0, 0, 0, 0);
      pulse_set(23, 59, 59);
      wait_drain("write_235959", 100);

      // Periodic reads: decode, masking, invalid BCD, range errors, recovery
      enable = 1;
      startTimes.delete();
      for (int i = 0; i < 8; i++) begin
         rdData = pollData[i];
         push(0, 1, 32'h0, 3, 0, 0, 0, 0, 0);
         push(3, 0, 0, 0, pollExp[i][0], pollExp[i][1], pollExp[i][2], 1, pollExp[i][3]);
         wait_drain("poll_read", 300);
         if (i > 0 && startTimes.size() == i + 1)
            check("poll_interval", startTimes[i] - startTimes[i-1], PollCycles);
      end

      // No-acknowledge on every attempt: 1 + 3 retries, then error, time kept
      nackAll = 1;
      for (int i = 0; i < 4; i++) push(0, 1, 32'h0, 3, 0, 0, 0, 0, 0);
      push(3, 0, 0, 0, 10, 20, 30, 1, 1);
      wait_drain("nack_retries", 400);
      repeat (40) @(negedge clock);
      enable  = 0;
      nackAll = 0;

      // First attempt times out in WaitBusy, retry succeeds and clears error
      ignoreCnt = 1;
      push(0, 4, 32'h01020300, 0, 0, 0, 0, 0, 0);
      push(0, 4, 32'h01020300, 0, 0, 0, 0, 0, 0);
      push(2, 0, 0, 0, 0, 0, 0, 0, 0);
      push(3, 0, 0, 0, 10, 20, 30, 1, 0);
      pulse_set(1, 2, 3);
      wait_drain("timeout_retry", 200);

      // Reset during WaitDone
      push(0, 4, 32'h05060700, 0, 0, 0, 0, 0, 0);
      pulse_set(5, 6, 7);
      n = 0;
      while (i2cReady && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("reached_wait_done", int'(i2cReady), 0);
      @(negedge clock);
      push(3, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 reset = 1;
      #1;
      check("async_reset_hours", int'(hours), 0);
      check("async_reset_minutes", int'(minutes), 0);
      check("async_reset_seconds", int'(seconds), 0);
      check("async_reset_time_valid", int'(timeValid), 0);
      check("async_reset_busy", int'(busy), 0);
      check("async_reset_send_count", int'(i2cNrOfBytesToSend), 0);
      repeat (3) @(negedge clock);
      wait_drain("reset_busy_drop", 5);
      reset  = 0;
      relCyc = cyc;
      enable = 1;
      rdData = 24'h131415;
      startTimes.delete();
      push(0, 1, 32'h0, 3, 0, 0, 0, 0, 0);
      push(3, 0, 0, 0, 13, 14, 15, 1, 0);
      wait_drain("post_reset_poll", 300);
      if (startTimes.size() > 0)
         check("post_reset_first_poll", startTimes[0] - relCyc, PollCycles + 1);

      enable = 0;
      repeat (10) @(negedge clock);
      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
